// File: rtl/inject_arb_pkg.sv
// Shared types and constants for the injector-link arbiter.
// Optional watchdog in the top is enabled with INJ_ARB_WATCHDOG_EN.
package inject_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    localparam int unsigned FLIT_SIZE_DEFAULT  = 32;
    localparam int unsigned WDT_CYCLES_DEFAULT = 1024;

    typedef logic [FLIT_SIZE_DEFAULT-1:0] flit_t;

    // Round-robin pointer width; a lone source still gets a 1-bit pointer.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Rotating-priority encoder: the first request at or after ptr wins,
// scanning upward and wrapping from N-1 to 0.
module rr_picker #(
    parameter int N  = 2,
    parameter int PW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic          valid
);

    int  idx;
    logic found;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr) + i) % N;
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

    assign valid = |req;

endmodule

// File: rtl/inject_arbiter.sv
// Message-granular round-robin arbiter sharing the injector flit link.
// Define INJ_ARB_WATCHDOG_EN to build the stall watchdog.
module inject_arbiter
    import inject_arb_pkg::*;
#(
    parameter int N_SRC      = 2,
    parameter int FLIT_SIZE  = 32,
    parameter int WDT_CYCLES = WDT_CYCLES_DEFAULT
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic [N_SRC-1:0]                src_tx_i,
    input  logic [N_SRC-1:0]                src_last_i,
    input  logic [N_SRC-1:0][FLIT_SIZE-1:0] src_data_i,
    output logic [N_SRC-1:0]                src_credit_o,
    input  logic [N_SRC-1:0]                src_eoa_i,
    output logic                            tx_o,
    input  logic                            credit_i,
    output logic [FLIT_SIZE-1:0]            data_o,
    output logic                            eoa_o,
    output logic [N_SRC-1:0]                grant_o,
    output logic                            wdt_err_o
);

    localparam int PW = ptr_width(N_SRC);

    if (N_SRC < 1 || WDT_CYCLES < 2) begin : g_bad_param
        $error("inject_arbiter: N_SRC must be >= 1 and WDT_CYCLES >= 2");
    end

    arb_state_e        state_q, state_d;
    logic [N_SRC-1:0]  grant_q, grant_d;
    logic [PW-1:0]     ptr_q, ptr_d, nxt_ptr;
    logic [N_SRC-1:0]  pick_gnt;
    logic              pick_valid;
    logic              gnt_last;
    logic              xfer;
    logic              wdt_fire;
    logic              eoa_q;

    rr_picker #(
        .N  (N_SRC),
        .PW (PW)
    ) u_picker (
        .req   (src_tx_i),
        .ptr   (ptr_q),
        .gnt   (pick_gnt),
        .valid (pick_valid)
    );

    // Granted source drives the link straight through, no pipeline stage.
    always_comb begin
        tx_o         = 1'b0;
        data_o       = '0;
        src_credit_o = '0;
        gnt_last     = 1'b0;
        nxt_ptr      = '0;
        if (state_q == LOCKED) begin
            for (int i = 0; i < N_SRC; i++) begin
                if (grant_q[i]) begin
                    tx_o            = src_tx_i[i];
                    data_o          = src_data_i[i];
                    src_credit_o[i] = credit_i;
                    gnt_last        = src_last_i[i];
                    nxt_ptr         = (i == N_SRC - 1) ? '0 : PW'(i + 1);
                end
            end
        end
    end

    assign xfer = tx_o && credit_i;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    grant_d = pick_gnt;
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                // Normal end of message or watchdog release both hand the link on.
                if ((xfer && gnt_last) || wdt_fire) begin
                    grant_d = '0;
                    state_d = IDLE;
                    ptr_d   = nxt_ptr;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            eoa_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            eoa_q   <= (&src_eoa_i) && (state_q == IDLE) && !(|src_tx_i);
        end
    end

    assign grant_o = grant_q;
    assign eoa_o   = eoa_q;

`ifdef INJ_ARB_WATCHDOG_EN
    localparam int WW = $clog2(WDT_CYCLES + 1);

    logic [WW-1:0] wdt_cnt_q;
    logic          wdt_err_q;

    assign wdt_fire = (state_q == LOCKED) && !xfer && (wdt_cnt_q == WW'(WDT_CYCLES - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wdt_cnt_q <= '0;
            wdt_err_q <= 1'b0;
        end else begin
            if (state_q != LOCKED || xfer || wdt_fire) begin
                wdt_cnt_q <= '0;
            end else begin
                wdt_cnt_q <= wdt_cnt_q + 1'b1;
            end
            if (wdt_fire) begin
                wdt_err_q <= 1'b1;
            end
        end
    end

    assign wdt_err_o = wdt_err_q;
`else
    assign wdt_fire  = 1'b0;
    assign wdt_err_o = 1'b0;
`endif

endmodule
